// File: rtl/puf_eval_if.sv
// Handshake/data bundle between the PUF evaluation sequencer and its environment
// (system request side plus oscillator/mux/counter array side).
interface puf_eval_if #(
    parameter int NBITS = 8,
    parameter int SEL_W = 3,
    parameter int CW    = 8
) ();
    logic             start;
    logic             abort;
    logic [SEL_W-1:0] chal;
    logic [CW-1:0]    count_a;
    logic [CW-1:0]    count_b;
    logic             ro_en;
    logic             cnt_clr;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             busy;
    logic [NBITS-1:0] resp;
    logic             resp_valid;
    logic             tie_seen;

    modport master (
        output start, abort, chal, count_a, count_b,
        input  ro_en, cnt_clr, sel_a, sel_b, busy, resp, resp_valid, tie_seen
    );

    modport slave (
        input  start, abort, chal, count_a, count_b,
        output ro_en, cnt_clr, sel_a, sel_b, busy, resp, resp_valid, tie_seen
    );
endinterface

// File: rtl/puf_eval_sequencer.sv
// Ring-oscillator PUF evaluation sequencer: walks challenge-derived oscillator pairs,
// gates/clears/samples the counters and builds an NBITS response. Macro PUF_MAJORITY_EN
// enables three-pass majority voting per bit.
module puf_eval_sequencer #(
    parameter int NBITS  = 8,
    parameter int SEL_W  = 3,
    parameter int CW     = 8,
    parameter int WINDOW = 64,
    parameter int HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    puf_eval_if.slave  bus
);
    localparam int K_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CNT_W = $clog2(WINDOW + HOLD + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_COUNT   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_SAMPLE  = 3'd4;
    localparam logic [2:0] S_COMPARE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [SEL_W-1:0] chal_q, chal_d;
    logic [NBITS-1:0] work_q, work_d;
    logic             tie_acc_q, tie_acc_d;
    logic [CW-1:0]    a_q, a_d;
    logic [CW-1:0]    b_q, b_d;
    logic [NBITS-1:0] resp_q, resp_d;
    logic             tie_seen_q, tie_seen_d;
    logic             ro_en_q, ro_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             busy_q, busy_d;
    logic             resp_valid_q, resp_valid_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d;
    logic [SEL_W-1:0] sel_b_q, sel_b_d;

    logic             gt;
    logic             eq;
    logic             bit_val;
    logic             last_meas;

`ifdef PUF_MAJORITY_EN
    logic [1:0]       pass_q, pass_d;
    logic [1:0]       vote_q, vote_d;
    logic [1:0]       vote_sum;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        k_d          = k_q;
        chal_d       = chal_q;
        work_d       = work_q;
        tie_acc_d    = tie_acc_q;
        a_d          = a_q;
        b_d          = b_q;
        resp_d       = resp_q;
        tie_seen_d   = tie_seen_q;

        gt           = (a_q > b_q);
        eq           = (a_q == b_q);
        bit_val      = gt;
        last_meas    = 1'b1;
`ifdef PUF_MAJORITY_EN
        pass_d       = pass_q;
        vote_d       = vote_q;
        vote_sum     = vote_q + {1'b0, gt};
        bit_val      = (vote_sum >= 2'd2);
        last_meas    = (pass_q == 2'd2);
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    chal_d    = bus.chal;
                    k_d       = '0;
                    work_d    = '0;
                    tie_acc_d = 1'b0;
`ifdef PUF_MAJORITY_EN
                    pass_d    = 2'd0;
                    vote_d    = 2'd0;
`endif
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = CNT_W'(WINDOW - 1);
                state_d = S_COUNT;
            end
            S_COUNT: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(HOLD - 1);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                a_d     = bus.count_a;
                b_d     = bus.count_b;
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                tie_acc_d = tie_acc_q | eq;
`ifdef PUF_MAJORITY_EN
                if (!last_meas) begin
                    pass_d  = pass_q + 2'd1;
                    vote_d  = vote_sum;
                    state_d = S_CLEAR;
                end else begin
                    pass_d  = 2'd0;
                    vote_d  = 2'd0;
                end
`endif
                if (last_meas) begin
                    work_d[k_q] = bit_val;
                    if (k_q == K_W'(NBITS - 1)) begin
                        // Publish on entry to DONE so resp is already valid alongside the pulse.
                        resp_d     = work_d;
                        tie_seen_d = tie_acc_d;
                        state_d    = S_DONE;
                    end else begin
                        k_d     = k_q + K_W'(1);
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including the publish of a finishing evaluation.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            resp_d     = resp_q;
            tie_seen_d = tie_seen_q;
        end

        ro_en_d      = (state_d == S_COUNT);
        cnt_clr_d    = (state_d == S_CLEAR);
        busy_d       = (state_d != S_IDLE);
        resp_valid_d = (state_d == S_DONE);
        sel_a_d      = chal_d + SEL_W'(k_d);
        sel_b_d      = sel_a_d + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            k_q          <= '0;
            chal_q       <= '0;
            work_q       <= '0;
            tie_acc_q    <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            resp_q       <= '0;
            tie_seen_q   <= 1'b0;
            ro_en_q      <= 1'b0;
            cnt_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            k_q          <= k_d;
            chal_q       <= chal_d;
            work_q       <= work_d;
            tie_acc_q    <= tie_acc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            resp_q       <= resp_d;
            tie_seen_q   <= tie_seen_d;
            ro_en_q      <= ro_en_d;
            cnt_clr_q    <= cnt_clr_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
        end
    end

`ifdef PUF_MAJORITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q <= 2'd0;
            vote_q <= 2'd0;
        end else begin
            pass_q <= pass_d;
            vote_q <= vote_d;
        end
    end
`endif

    assign bus.ro_en      = ro_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.sel_a      = sel_a_q;
    assign bus.sel_b      = sel_b_q;
    assign bus.busy       = busy_q;
    assign bus.resp       = resp_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.tie_seen   = tie_seen_q;
endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Bench for puf_eval_sequencer: behavioural counter responder, response scoreboard,
// vector table plus reset/abort/busy-start/majority sequences.
module tb_puf_eval_sequencer;
    localparam int NBITS  = 8;
    localparam int SEL_W  = 3;
    localparam int CW     = 8;
    localparam int WINDOW = 64;
    localparam int HOLD   = 4;
    localparam int P      = WINDOW + HOLD + 3;
`ifdef PUF_MAJORITY_EN
    localparam int PASSES = 3;
`else
    localparam int PASSES = 1;
`endif
    localparam int EXP_VALID = PASSES * NBITS * P + 1;
    localparam int LIMIT     = EXP_VALID + 50;

    typedef struct {
        logic [7:0] resp;
        logic       tie;
    } exp_t;

    typedef struct {
        logic [2:0] chal;
        int         mode;
        logic [7:0] resp;
        logic       tie;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   mode;
    logic [2:0] chal_cur;
    int   clr_seen;
    exp_t sb[$];
    vec_t vecs[6];

    puf_eval_if #(.NBITS(NBITS), .SEL_W(SEL_W), .CW(CW)) bus ();

    puf_eval_sequencer #(
        .NBITS(NBITS), .SEL_W(SEL_W), .CW(CW), .WINDOW(WINDOW), .HOLD(HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of counter clears seen in the current evaluation, used to tell majority passes apart.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_seen <= 0;
        else if (bus.start && !bus.busy && !bus.abort) clr_seen <= 0;
        else if (bus.cnt_clr) clr_seen <= clr_seen + 1;
    end

    logic [2:0] kk;
    int         pass;
    logic [7:0] ca, cb;
    always_comb begin
        kk   = bus.sel_a - chal_cur;
        pass = (clr_seen == 0) ? 0 : ((clr_seen - 1) % PASSES);
        ca   = 8'h00;
        cb   = 8'h00;
        case (mode)
            0: begin if (kk[0] == 1'b0) begin ca = 8'h50; cb = 8'h40; end
                     else begin ca = 8'h20; cb = 8'h30; end end
            1: begin if (kk == 3'd2) begin ca = 8'h22; cb = 8'h22; end
                     else begin ca = 8'h90; cb = 8'h10; end end
            2: begin ca = 8'h30; cb = 8'h31; end
            3: begin ca = 8'hFF; cb = 8'hFE; end
            4: begin if (kk < 3'd4) begin ca = 8'h00; cb = 8'hFF; end
                     else begin ca = 8'hFF; cb = 8'h00; end end
            5: begin ca = 8'h00; cb = 8'h00; end
            6: begin
                if (kk == 3'd0) begin
                    if (pass == 1) begin ca = 8'h10; cb = 8'h80; end
                    else begin ca = 8'h80; cb = 8'h10; end
                end else if (kk == 3'd1) begin
                    if (pass == 1) begin ca = 8'h80; cb = 8'h10; end
                    else begin ca = 8'h10; cb = 8'h80; end
                end else begin
                    ca = 8'h10; cb = 8'h80;
                end
            end
            default: begin ca = 8'h00; cb = 8'h00; end
        endcase
        bus.count_a = ca;
        bus.count_b = cb;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full evaluation; glitch_cyc>0 pulses an extra start with a different challenge mid-run.
    task automatic run_eval(input logic [2:0] c, input int m, input logic [7:0] er,
                            input logic et, input string name, input int glitch_cyc);
        exp_t       e;
        exp_t       got;
        int         cyc, vcyc, run_len, runs, bad_run, ovl, sel_bad, sel_chg, clr_n;
        logic [2:0] prev_sel, exp_sel;
        logic       b1, c1;
        mode     = m;
        chal_cur = c;
        e.resp   = er;
        e.tie    = et;
        sb.push_back(e);
        bus.chal  = c;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1; vcyc = -1; run_len = 0; runs = 0; bad_run = 0; ovl = 0;
        sel_bad = 0; sel_chg = 0; clr_n = 0; prev_sel = bus.sel_a; b1 = 1'b0; c1 = 1'b0;
        got.resp = 8'h00; got.tie = 1'b0;
        while (cyc <= LIMIT && vcyc < 0) begin
            if (cyc == 1) begin b1 = bus.busy; c1 = bus.cnt_clr; end
            if (bus.ro_en && bus.cnt_clr) ovl++;
            if (bus.ro_en) run_len++;
            else if (run_len > 0) begin
                runs++;
                if (run_len != WINDOW) bad_run++;
                run_len = 0;
            end
            if (bus.cnt_clr) begin
                exp_sel = c + 3'(clr_n / PASSES);
                if (bus.sel_a != exp_sel || bus.sel_b != exp_sel + 3'd1) sel_bad++;
                clr_n++;
            end
            if (cyc > 1 && bus.sel_a != prev_sel) sel_chg++;
            prev_sel = bus.sel_a;
            if (bus.resp_valid) begin
                vcyc     = cyc;
                got.resp = bus.resp;
                got.tie  = bus.tie_seen;
            end else begin
                if (cyc == glitch_cyc) begin
                    bus.start = 1'b1;
                    bus.chal  = c + 3'd3;
                end
                step();
                bus.start = 1'b0;
                cyc++;
            end
        end
        check({name, " busy_rise"}, 32'(b1), 32'd1);
        check({name, " clr_first"}, 32'(c1), 32'd1);
        check({name, " valid_cycle"}, 32'(vcyc), 32'(EXP_VALID));
        e = sb.pop_front();
        check({name, " resp"}, 32'(got.resp), 32'(e.resp));
        check({name, " tie_seen"}, 32'(got.tie), 32'(e.tie));
        check({name, " ro_en_runs"}, 32'(runs), 32'(PASSES * NBITS));
        check({name, " ro_en_len_bad"}, 32'(bad_run), 32'd0);
        check({name, " clr_ro_overlap"}, 32'(ovl), 32'd0);
        check({name, " sel_pairs_bad"}, 32'(sel_bad), 32'd0);
        check({name, " sel_changes"}, 32'(sel_chg), 32'(NBITS - 1));
        step();
        check({name, " busy_after"}, 32'(bus.busy), 32'd0);
        check({name, " valid_one_cycle"}, 32'(bus.resp_valid), 32'd0);
        $display("eval %s chal=%0d resp=0x%02h tie=%0b valid_cycle=%0d", name, c, got.resp, got.tie, vcyc);
    endtask

    initial begin
        int cyc;
        int pulses;
        int busy_seen;
        int abort_cyc;
        n_checks = 0; n_fail = 0;
        mode = 0; chal_cur = 3'd0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.chal = 3'd0;

        vecs[0] = '{3'd3, 0, 8'h55, 1'b0, "basic"};
        vecs[1] = '{3'd0, 1, 8'hFB, 1'b1, "tie_k2"};
        vecs[2] = '{3'd5, 2, 8'h00, 1'b0, "all_lt"};
        vecs[3] = '{3'd2, 5, 8'h00, 1'b1, "all_tie"};
        vecs[4] = '{3'd7, 4, 8'hF0, 1'b0, "extremes"};
        vecs[5] = '{3'd6, 3, 8'hFF, 1'b0, "wrap_c6"};

        repeat (3) @(posedge clk);
        #1;
        check("rst ro_en", 32'(bus.ro_en), 32'd0);
        check("rst cnt_clr", 32'(bus.cnt_clr), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst resp", 32'(bus.resp), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst sels", {26'd0, bus.sel_a, bus.sel_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_eval(vecs[i].chal, vecs[i].mode, vecs[i].resp, vecs[i].tie, vecs[i].name, 0);
        end

        // Asynchronous reset in the middle of a COUNT window.
        mode = 0; chal_cur = 3'd1; bus.chal = 3'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        check("midrst ro_en_before", 32'(bus.ro_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst ro_en", 32'(bus.ro_en), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst resp", 32'(bus.resp), 32'd0);
        check("midrst resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check("postrst idle", {29'd0, bus.busy, bus.ro_en, bus.cnt_clr}, 32'd0);
        $display("reset mid-count done");

        run_eval(3'd3, 0, 8'h55, 1'b0, "basic2", 0);

        // Abort during the HOLD phase of bit 4, with a simultaneous start.
        abort_cyc = 4 * PASSES * P + WINDOW + 3;
        mode = 3; chal_cur = 3'd2; bus.chal = 3'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < abort_cyc) begin
            step();
            cyc++;
        end
        check("abort in_hold", {30'd0, bus.busy, bus.ro_en}, 32'h2);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort ro_en", 32'(bus.ro_en), 32'd0);
        check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort resp_kept", 32'(bus.resp), 32'h55);
        check("abort tie_kept", 32'(bus.tie_seen), 32'd0);
        pulses = 0; busy_seen = 0;
        repeat (EXP_VALID) begin
            step();
            if (bus.resp_valid) pulses++;
            if (bus.busy) busy_seen++;
        end
        check("abort no_pulse", 32'(pulses), 32'd0);
        check("abort stays_idle", 32'(busy_seen), 32'd0);
        $display("abort in bit 4 hold done");

        // Start together with abort in IDLE is not accepted.
        bus.abort = 1'b1; bus.start = 1'b1;
        step();
        bus.abort = 1'b0; bus.start = 1'b0;
        step();
        check("start_abort_idle busy", 32'(bus.busy), 32'd0);
        $display("start+abort in idle done");

        run_eval(3'd4, 2, 8'h00, 1'b0, "busy_start", 100);

`ifdef PUF_MAJORITY_EN
        run_eval(3'd0, 6, 8'h01, 1'b0, "majority", 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
